// File: rtl/ad7643_serial_tx.sv
// Purpose: AD7643-style ADC stand-in; on a CNVST fall it holds BUSY, then shifts a word out MSB-first with SYNC/SCLK.
// Latency: BUSY one cycle after the trigger, SYNC/MSB after CONV_CYC more, DONE after 2*DATA_W*SCLK_DIV shift cycles.
// Backpressure: none; a trigger while a frame is in flight is dropped and recorded in the sticky OVERRUN flag.
module ad7643_serial_tx #(
    parameter int DATA_W   = 18,
    parameter int CONV_CYC = 60,
    parameter int SCLK_DIV = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CNVST,
    input  logic              CS,
    input  logic              MODE,
    input  logic [DATA_W-1:0] SAMPLE,
    input  logic              CLR_OVR,
    output logic              BUSY,
    output logic              SYNC,
    output logic              SCLK,
    output logic              SDOUT,
    output logic              DONE,
    output logic              OVERRUN,
    output logic [15:0]       CONV_CNT
);

    localparam int CONV_W = 10;
    localparam int DIV_W  = 4;
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t              state_q;
    logic                cnvst_q;
    logic [DATA_W-1:0]   word_q;
    logic [DATA_W-1:0]   ramp_q;
    logic                mode_q;
    logic [CONV_W-1:0]   conv_q;
    logic [DIV_W-1:0]    div_q;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q;
    logic                sync_q;
    logic                sclk_q;
    logic                sdout_q;
    logic                done_q;
    logic                ovr_q;
    logic                ovr_d;
    logic [15:0]         cnt_q;
    logic                trig;

    // A trigger is a high-to-low CNVST transition; the copy resets low so a
    // CNVST already held low when reset releases is not taken as an edge.
    assign trig = cnvst_q & ~CNVST;

    // Registered copy of CNVST for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnvst_q <= 1'b0;
        end else begin
            cnvst_q <= CNVST;
        end
    end

    // Conversion / shift sequencer with registered BUSY, SYNC, SCLK, SDOUT, DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            ramp_q  <= '0;
            mode_q  <= 1'b0;
            conv_q  <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            sync_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdout_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        // Word source and mode are frozen here for the whole frame.
                        word_q  <= MODE ? ramp_q : SAMPLE;
                        mode_q  <= MODE;
                        conv_q  <= CONV_W'(CONV_CYC - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (conv_q == '0) begin
                        idx_q   <= IDX_W'(DATA_W - 1);
                        div_q   <= DIV_W'(SCLK_DIV - 1);
                        sync_q  <= 1'b1;
                        sclk_q  <= 1'b0;
                        sdout_q <= word_q[DATA_W-1];
                        state_q <= S_SHIFT;
                    end else begin
                        conv_q <= conv_q - CONV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_q == '0) begin
                        div_q <= DIV_W'(SCLK_DIV - 1);
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Falling SCLK: the only point where SDOUT may move.
                            sclk_q <= 1'b0;
                            if (idx_q == '0) begin
                                busy_q  <= 1'b0;
                                sync_q  <= 1'b0;
                                sdout_q <= 1'b0;
                                done_q  <= 1'b1;
                                cnt_q   <= cnt_q + 16'd1;
                                if (mode_q) begin
                                    ramp_q <= ramp_q + DATA_W'(1);
                                end
                                state_q <= S_IDLE;
                            end else begin
                                idx_q   <= idx_q - IDX_W'(1);
                                sdout_q <= word_q[idx_q - IDX_W'(1)];
                            end
                        end
                    end else begin
                        div_q <= div_q - DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Overrun: set on any trigger outside IDLE (including the last shift
    // cycle); a simultaneous clear loses to the set.
    always_comb begin
        ovr_d = ovr_q;
        if (trig && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end else if (CLR_OVR) begin
            ovr_d = 1'b0;
        end
    end

    // Sticky overrun register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    // CS only gates the pins; sequencing carries on underneath.
    assign BUSY     = busy_q;
    assign SYNC     = sync_q;
    assign SCLK     = sclk_q & ~CS;
    assign SDOUT    = sdout_q & ~CS;
    assign DONE     = done_q;
    assign OVERRUN  = ovr_q;
    assign CONV_CNT = cnt_q;

endmodule

// File: tb/tb_ad7643_serial_tx.sv
// Purpose: randomized self-checking bench for ad7643_serial_tx against a frame-level reference model.
// Latency: frames are checked by arithmetic timing expectations relative to the trigger edge.
// Backpressure: not applicable; every wait is a fixed-length cycle loop.
module tb_ad7643_serial_tx;

    localparam int DW    = 18;
    localparam int CC    = 60;
    localparam int SD    = 2;
    localparam int FRAME = CC + 2 * DW * SD;

    localparam int DW2    = 4;
    localparam int CC2    = 3;
    localparam int SD2    = 1;
    localparam int FRAME2 = CC2 + 2 * DW2 * SD2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnvst, cs, mode, clr_ovr;
    logic [DW-1:0] sample;
    logic          busy, sync, sclk, sdout, done, overrun;
    logic [15:0]   conv_cnt;

    logic           cnvst2, cs2, mode2, clr2;
    logic [DW2-1:0] sample2;
    logic           s_busy, s_sync, s_sclk, s_sdout, s_done, s_ovr;
    logic [15:0]    s_cnt;

    always #5 clk = ~clk;

    ad7643_serial_tx #(.DATA_W(DW), .CONV_CYC(CC), .SCLK_DIV(SD)) dut (
        .CLK(clk), .RST(rst), .CNVST(cnvst), .CS(cs), .MODE(mode),
        .SAMPLE(sample), .CLR_OVR(clr_ovr), .BUSY(busy), .SYNC(sync),
        .SCLK(sclk), .SDOUT(sdout), .DONE(done), .OVERRUN(overrun),
        .CONV_CNT(conv_cnt)
    );

    ad7643_serial_tx #(.DATA_W(DW2), .CONV_CYC(CC2), .SCLK_DIV(SD2)) dut_small (
        .CLK(clk), .RST(rst), .CNVST(cnvst2), .CS(cs2), .MODE(mode2),
        .SAMPLE(sample2), .CLR_OVR(clr2), .BUSY(s_busy), .SYNC(s_sync),
        .SCLK(s_sclk), .SDOUT(s_sdout), .DONE(s_done), .OVERRUN(s_ovr),
        .CONV_CNT(s_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          exp_cnt  = 0;
    logic [DW-1:0] exp_ramp = '0;
    bit          exp_ovr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cnvst   = 1'b1;
            clr_ovr = 1'b0;
        end
    endtask

    // Issues a trigger now (caller is just past a negedge) and observes one
    // frame window. t1/t2: extra CNVST pulses; clr_j: CLR_OVR pulse; rst_j: RST pulse.
    task automatic run_frame(input logic [DW-1:0] smp, input bit md, input bit csv,
                             input int t1, input int t2, input int clr_j, input int rst_j);
        int busy_n = 0, busy_first = 0, sync_n = 0, sync_first = 0;
        int rises = 0, first_rise = 0, done_n = 0, done_j = 0;
        int glitch = 0, leak = 0;
        logic [DW-1:0] word = '0;
        logic [DW-1:0] exp_w;
        logic prev_sclk = 1'b0, prev_sdout = 1'b0;
        exp_w  = md ? exp_ramp : smp;
        mode   = md;
        sample = smp;
        cs     = csv;
        cnvst  = 1'b0;
        for (int j = 1; j <= FRAME + 1; j++) begin
            @(negedge clk);
            if (rst_j > 0 && j == rst_j + 1) begin
                chk("rst_midframe_outs", 32'({busy, sync, sclk, sdout, done, overrun}), 32'd0);
                chk("rst_midframe_cnt", 32'(conv_cnt), 32'd0);
            end
            if (busy) begin busy_n++; if (busy_first == 0) busy_first = j; end
            if (sync) begin sync_n++; if (sync_first == 0) sync_first = j; end
            if (sclk && !prev_sclk) begin
                rises++;
                if (first_rise == 0) first_rise = j;
                word = {word[DW-2:0], sdout};
            end
            if (sclk && prev_sclk && (sdout !== prev_sdout)) glitch++;
            if (csv && (sclk || sdout)) leak++;
            if (done) begin done_n++; done_j = j; end
            prev_sclk  = sclk;
            prev_sdout = sdout;
            // drive next inputs and update the model's view of control events
            cnvst   = (j == t1 || j == t2) ? 1'b0 : 1'b1;
            clr_ovr = (j == clr_j);
            rst     = (j == rst_j);
            if (j == t1 || j == t2) exp_ovr = 1'b1;
            else if (j == clr_j) exp_ovr = 1'b0;
            if (j == rst_j) begin
                exp_cnt  = 0;
                exp_ramp = '0;
                exp_ovr  = 1'b0;
            end
        end
        if (rst_j > 0) begin
            chk("rst_no_done", 32'(done_n), 32'd0);
            chk("rst_busy_cleared", 32'(busy), 32'd0);
        end else begin
            chk("busy_first", 32'(busy_first), 32'd1);
            chk("busy_len", 32'(busy_n), 32'(FRAME));
            chk("sync_first", 32'(sync_first), 32'(CC + 1));
            chk("sync_len", 32'(sync_n), 32'(2 * DW * SD));
            chk("done_count", 32'(done_n), 32'd1);
            chk("done_pos", 32'(done_j), 32'(FRAME + 1));
            if (csv) begin
                chk("cs_sclk_rises", 32'(rises), 32'd0);
                chk("cs_pin_leak", 32'(leak), 32'd0);
            end else begin
                chk("sclk_rises", 32'(rises), 32'(DW));
                chk("first_rise", 32'(first_rise), 32'(CC + 1 + SD));
                chk("word", 32'(word), 32'(exp_w));
                chk("sdout_stable_high", 32'(glitch), 32'd0);
            end
            exp_cnt++;
            if (md) exp_ramp = exp_ramp + 1'b1;
            chk("conv_cnt", 32'(conv_cnt), 32'(exp_cnt));
        end
        chk("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    // Small instance: one frame, words captured on SCLK rises.
    task automatic run_small(output logic [DW2-1:0] w, output int dn);
        logic ps = 1'b0;
        w      = '0;
        dn     = 0;
        cnvst2 = 1'b0;
        for (int j = 1; j <= FRAME2 + 1; j++) begin
            @(negedge clk);
            if (s_sclk && !ps) w = {w[DW2-2:0], s_sdout};
            if (s_done) dn++;
            ps     = s_sclk;
            cnvst2 = 1'b1;
        end
    endtask

    initial begin
        logic [DW2-1:0] w2;
        int dn2;
        rst = 1'b1; cnvst = 1'b1; cs = 1'b0; mode = 1'b0; clr_ovr = 1'b0; sample = '0;
        cnvst2 = 1'b1; cs2 = 1'b0; mode2 = 1'b1; clr2 = 1'b0; sample2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({busy, sync, sclk, sdout, done, overrun}), 32'd0);
        chk("reset_cnt", 32'(conv_cnt), 32'd0);
        rst = 1'b0;
        idle(3);

        // Known pattern from the SAMPLE input
        run_frame(18'h2A5A5, 1'b0, 1'b0, 0, 0, 0, 0);

        // Ramp frames back-to-back, each trigger issued in the cycle after DONE
        for (int k = 0; k < 5; k++)
            run_frame(DW'($urandom), 1'b1, 1'b0, 0, 0, 0, 0);

        // Overrun during CONV and on the last SHIFT cycle
        run_frame(DW'($urandom), 1'b0, 1'b0, 30, FRAME, 0, 0);
        idle(2);
        // Clear coinciding with a new overrun: set wins
        run_frame(DW'($urandom), 1'b0, 1'b0, 40, 0, 40, 0);
        idle(1);
        clr_ovr = 1'b1;
        exp_ovr = 1'b0;
        idle(2);
        chk("clr_ovr_alone", 32'(overrun), 32'(exp_ovr));

        // CS held high across a frame
        run_frame(DW'($urandom), 1'b0, 1'b1, 0, 0, 0, 0);
        cs = 1'b0;

        // Random mode/sample frames
        for (int k = 0; k < 4; k++)
            run_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 0, 0);

        // Reset during SHIFT at bit index 9, then full frames
        run_frame(DW'($urandom), 1'b1, 1'b0, 0, 0, 0, CC + 1 + (DW - 1 - 9) * 2 * SD);
        idle(2);
        run_frame(DW'($urandom), 1'b1, 1'b0, 0, 0, 0, 0);
        run_frame(DW'($urandom), 1'b0, 1'b0, 0, 0, 0, 0);

        // Ramp wrap on a narrow instance: words count 0..15 then wrap to 0
        idle(2);
        for (int k = 0; k <= (1 << DW2); k++) begin
            run_small(w2, dn2);
            chk("small_word", 32'(w2), 32'(k % (1 << DW2)));
            chk("small_done", 32'(dn2), 32'd1);
        end
        chk("small_cnt", 32'(s_cnt), 32'((1 << DW2) + 1));
        chk("small_ovr", 32'(s_ovr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
